// File: rtl/seq_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_evt_pkg
// Purpose  : Default sizing and pointer helper for the sequence event logger.
// Revision : 1.0
// ============================================================================
package seq_evt_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int CNT_WIDTH_DEF = 8;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_event_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : sequence_event_logger_if
// Purpose  : Detection input, host drain handshake and status outputs.
// Revision : 1.0
// ============================================================================
interface sequence_event_logger_if import seq_evt_pkg::*; #(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 sequence_found;
    logic                 clear;
    logic                 evt_ready;
    logic                 evt_valid;
    logic [TS_WIDTH-1:0]  evt_timestamp;
    logic [CNT_WIDTH-1:0] evt_count;
    logic                 overflow;

    modport slave (
        input  sequence_found, clear, evt_ready,
        output evt_valid, evt_timestamp, evt_count, overflow
    );

    modport master (
        output sequence_found, clear, evt_ready,
        input  evt_valid, evt_timestamp, evt_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : event_fifo
// Purpose  : First-word-fall-through FIFO; a push while full is accepted only
//            when a pop happens on the same edge.
// Revision : 1.0
// ============================================================================
module event_fifo import seq_evt_pkg::*; #(
    parameter int WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  drop_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             w_empty, w_full, w_pop, w_push_acc;

    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_pop      = pop_i && !w_empty;
    assign w_push_acc = push_i && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(w_push_acc);
        rd_ptr_d = rd_ptr_q + PW'(w_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read mux masks it whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign valid_o = !w_empty;
    assign data_o  = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign drop_o  = push_i && !w_push_acc;

endmodule
`default_nettype wire

// File: rtl/sequence_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : sequence_event_logger
// Purpose  : Timestamps detector pulses into a FIFO; saturating match count
//            and sticky overflow flag with synchronous clear.
// Revision : 1.0
// ============================================================================
module sequence_event_logger import seq_evt_pkg::*; #(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  wire logic clk,
    input  wire logic reset_n,
    sequence_event_logger_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 w_drop;

    event_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (bus.sequence_found),
        .pop_i   (bus.evt_ready),
        .data_i  (ts_q),
        .data_o  (bus.evt_timestamp),
        .valid_o (bus.evt_valid),
        .drop_o  (w_drop)
    );

    // Clear wins over count/flag updates but never blocks the FIFO push.
    always_comb begin
        ts_d  = ts_q + TS_WIDTH'(1);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (bus.sequence_found && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            if (w_drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.evt_count = cnt_q;
    assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: doc/sequence_event_logger.md
# sequence_event_logger

Downstream consumer of the sequence detector's `sequence_found` pulse. It timestamps every detection against a free-running cycle counter and buffers the timestamps in a small first-word-fall-through FIFO, which a host drains over a valid/ready handshake. It also keeps a saturating total-match count and a sticky overflow flag for events dropped while the FIFO is full.

## Interface
- `TS_WIDTH`, 16: width of the timestamp counter and of each FIFO entry.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `CNT_WIDTH`, 8: width of the saturating match counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sequence_found`  in  1  detection pulse from the detector, sampled on each rising edge.
- `clear`  in  1  synchronous clear of `evt_count` and `overflow`.
- `evt_ready`  in  1  host accepts the head entry.
- `evt_valid`  out  1  FIFO is not empty.
- `evt_timestamp`  out  TS_WIDTH  timestamp of the head entry; 0 when the FIFO is empty.
- `evt_count`  out  CNT_WIDTH  total detections since reset or clear, saturating.
- `overflow`  out  1  sticky: at least one event was dropped.

## Operation
- **Timestamp counter `ts`:**
  - 0 at reset.
  - Increments by 1 on every rising edge while `reset_n` is high.
  - Wraps modulo 2^TS_WIDTH.
- **Event capture:** an event is a rising edge with `sequence_found` = 1. The entry written is the pre-increment `ts` value. The first edge after reset release therefore stamps 0.
- **Push:**
  - Accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the event is dropped and `overflow` is set to 1.
- **Pop:** occurs on an edge where `evt_valid` && `evt_ready`. `evt_ready` while empty is ignored.
- **Simultaneous push and pop:**
  - When empty: only the push takes effect.
  - When partially filled: occupancy is unchanged.
  - When full: the push is accepted and `overflow` is not set.
- **`evt_count`:**
  - Increments on every event, whether stored or dropped.
  - Saturates at 2^CNT_WIDTH−1.
- **`clear`:**
  - Has priority over increment and set. With `clear` = 1, `evt_count` becomes 0 and `overflow` becomes 0, even if an event occurs on the same edge.
  - The FIFO contents and `ts` are unaffected. An event on the same edge is still pushed.
- **FIFO implementation:**
  - Read and write pointers are log2(DEPTH)+1 bits wide.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.

## Timing
- **Reset:** asserting `reset_n` low at any time immediately forces:
  - `ts` = 0, pointers = 0;
  - `evt_valid` = 0, `evt_timestamp` = 0;
  - `evt_count` = 0, `overflow` = 0.
  - Pending entries are discarded, and no event is captured while in reset.
- **Latency:** an event at edge N makes `evt_valid` = 1, with its timestamp on `evt_timestamp`, immediately after edge N. A pop at edge N presents the next entry after edge N.
- **Throughput:** one push and one pop per cycle.
- **Combinational paths:** `evt_valid` and `evt_timestamp` are driven from registers and the FIFO array only. There is no combinational path from `evt_ready` or `sequence_found` to any output.
- **Handshake:** `evt_timestamp` is held stable while `evt_valid` && !`evt_ready`.
- **Back-to-back events:** `sequence_found` held high for k edges produces k events with consecutive timestamps.

## Structure
- **Package `seq_evt_pkg`:** holds the default values of `TS_WIDTH`, `DEPTH` and `CNT_WIDTH`, and a `ptr_width` function (log2(DEPTH)+1).
- **Sub-module `event_fifo`:** a parameterised synchronous FWFT FIFO (WIDTH, DEPTH) with push/pop, full/empty and the full-with-pop push-accept rule.
- **Top level:** holds the timestamp counter, the saturating counter, the overflow flag and the clear logic.

## Test plan
- **Basic capture:** release reset; pulse `sequence_found` on edges 5 and 9 with `evt_ready` = 0 -> `evt_valid` = 1 and `evt_timestamp` = 5, `evt_count` = 2. Then one cycle with `evt_ready` = 1 -> `evt_timestamp` = 9. A second pop -> `evt_valid` = 0 and `evt_timestamp` = 0.
- **Overflow:** `DEPTH` = 4, `evt_ready` = 0; 6 events on edges 0–5 -> FIFO holds 0, 1, 2, 3; `overflow` = 1; `evt_count` = 6. Then `clear` for one edge -> `evt_count` = 0 and `overflow` = 0, with the FIFO still holding 4 entries.
- **Full with simultaneous pop and push:** FIFO full (0, 1, 2, 3); event on edge 7 with `evt_ready` = 1 -> head becomes 1, the tail entry is 7, and `overflow` stays 0.
- **Saturation and wrap:**
  - `CNT_WIDTH` = 8: 300 events -> `evt_count` = 255.
  - `TS_WIDTH` = 4: an event on edge 17 -> stored timestamp 1.
- **Reset mid-operation:** 3 entries buffered and `evt_count` = 3; pulse `reset_n` low between edges -> all outputs read 0 at once. An event on the first edge after release stamps 0.
